bcd_pulse_counter_nd: RTL

- Parametrised N-digit decimal pulse counter with 7-segment outputs; next generation of the fixed 3-digit tram/chuc/donvi counter.
- Synchronises an asynchronous pulse input, counts its rising edges up or down in BCD, and flags overflow and underflow.
- Outputs both raw BCD and registered 7-segment patterns, with optional leading-zero blanking.
- Sits between an external pulse source and the display drivers.

---
 rtl/bcd_pulse_counter_nd.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bcd_pulse_counter_nd.sv
// N-digit BCD up/down pulse counter with synchronised pulse input, sticky
// overflow/underflow flags and registered 7-segment decode.
module bcd_pulse_counter_nd #(
  parameter int DIGITS         = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int WRAP_MODE      = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_num_i,
  input  logic                  i_dir,
  input  logic                  i_hold,
  input  logic                  i_clr,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [7*DIGITS-1:0]   o_seg,
  output logic                  o_of,
  output logic                  o_uf
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;

  // Active-high pattern {g,f,e,d,c,b,a}; codes 10..15 decode to blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  function automatic logic [SW-1:0] decode_all(input logic [BW-1:0] v);
    logic [SW-1:0] r;
    logic          hi_zero;
    logic          blank;
    logic [6:0]    p;
    r       = '0;
    hi_zero = 1'b1;
    // Walk from the most significant digit so hi_zero covers "this and all above".
    for (int j = DIGITS - 1; j >= 0; j--) begin
      hi_zero = hi_zero & (v[4*j +: 4] == 4'd0);
      blank   = (BLANK_LZ != 0) && (j > 0) && hi_zero;
      p       = blank ? 7'h00 : seg7(v[4*j +: 4]);
      r[7*j +: 7] = (SEG_ACTIVE_LOW != 0) ? ~p : p;
    end
    return r;
  endfunction

  localparam logic [SW-1:0] SEG_RST = decode_all('0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [BW-1:0]          count_q, count_d;
  logic [SW-1:0]          seg_q;
  logic                   of_q, of_d;
  logic                   uf_q, uf_d;
  logic                   sync_last;
  logic                   ev;
  logic [BW-1:0]          inc_val, dec_val;
  logic                   at_max, at_zero;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign ev        = sync_last & ~prev_q;

  // Ripple carry/borrow; the final carry/borrow out marks all-9s / all-0s.
  always_comb begin
    logic c;
    logic b;
    c       = 1'b1;
    b       = 1'b1;
    inc_val = count_q;
    dec_val = count_q;
    for (int j = 0; j < DIGITS; j++) begin
      if (c) begin
        if (count_q[4*j +: 4] == 4'd9) begin
          inc_val[4*j +: 4] = 4'd0;
        end else begin
          inc_val[4*j +: 4] = count_q[4*j +: 4] + 4'd1;
          c = 1'b0;
        end
      end
      if (b) begin
        if (count_q[4*j +: 4] == 4'd0) begin
          dec_val[4*j +: 4] = 4'd9;
        end else begin
          dec_val[4*j +: 4] = count_q[4*j +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    at_max  = c;
    at_zero = b;
  end

  always_comb begin
    count_d = count_q;
    of_d    = of_q;
    uf_d    = uf_q;
    if (i_clr) begin
      count_d = '0;
      of_d    = 1'b0;
      uf_d    = 1'b0;
    end else if (ev && !i_hold) begin
      if (!i_dir) begin
        if (at_max) of_d = 1'b1;
        count_d = (at_max && WRAP_MODE == 0) ? count_q : inc_val;
      end else begin
        if (at_zero) uf_d = 1'b1;
        count_d = (at_zero && WRAP_MODE == 0) ? count_q : dec_val;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      count_q <= '0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
      seg_q   <= SEG_RST;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_num_i};
      prev_q  <= sync_last;
      count_q <= count_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
      seg_q   <= decode_all(count_q);
    end
  end

  assign o_bcd = count_q;
  assign o_seg = seg_q;
  assign o_of  = of_q;
  assign o_uf  = uf_q;

endmodule
